// File: rtl/snake_tile_renderer.sv
// Tile-map pixel source for a snake game: 40x30 map of 2-bit tile codes, FIFO-buffered writes
// committed only during vsync, a full-map wipe on CLEAR_REQ, and a zero-latency colour lookup.
module snake_tile_renderer #(
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [11:0] COL_EMPTY  = 12'h000,
  parameter logic [11:0] COL_BODY   = 12'h0F0,
  parameter logic [11:0] COL_HEAD   = 12'hFF0,
  parameter logic [11:0] COL_FOOD   = 12'hF00
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [9:0]  ADDRH,
  input  logic [8:0]  ADDRV,
  input  logic        VS,
  output logic [11:0] COLOUR_IN,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [5:0]  WR_COL,
  input  logic [4:0]  WR_ROW,
  input  logic [1:0]  WR_TILE,
  input  logic        CLEAR_REQ,
  output logic        CLEAR_BUSY
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [10:0]        clr_cnt_q, clr_cnt_d;
  logic [12:0]        fifo_q [FIFO_DEPTH];
  logic [1:0]         map_q [CELLS];

  logic               fifo_full, fifo_empty, push, pop, flush;
  logic [5:0]         head_col;
  logic [4:0]         head_row;
  logic [1:0]         head_tile;
  logic               head_in_grid;
  logic               map_we;
  logic [10:0]        map_waddr;
  logic [1:0]         map_wdata;

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign WR_READY   = !fifo_full && (state_q != ST_CLEAR);
  assign CLEAR_BUSY = (state_q == ST_CLEAR);
  assign push       = WR_VALID && WR_READY;

  assign {head_col, head_row, head_tile} = fifo_q[rd_ptr_q];
  assign head_in_grid = (32'(head_col) < GRID_W) && (32'(head_row) < GRID_H);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pop       = 1'b0;
    flush     = 1'b0;
    map_we    = 1'b0;
    map_waddr = clr_cnt_q;
    map_wdata = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (CLEAR_REQ) begin
          flush     = 1'b1;
          clr_cnt_d = '0;
          state_d   = ST_CLEAR;
        end else if (!VS && !fifo_empty) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (CLEAR_REQ) begin
          flush     = 1'b1;
          clr_cnt_d = '0;
          state_d   = ST_CLEAR;
        end else if (VS || fifo_empty) begin
          state_d = ST_IDLE;
        end else begin
          pop       = 1'b1;
          map_we    = head_in_grid;
          map_waddr = 11'(head_row) * 11'(GRID_W) + 11'(head_col);
          map_wdata = head_tile;
          if (count_q == (PTR_W+1)'(1) && !push) state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        map_we = 1'b1;
        if (clr_cnt_q == 11'(CELLS - 1)) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 11'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; the FIFO is emptied via its pointers and the map by the wipe.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {WR_COL, WR_ROW, WR_TILE};
    if (map_we) map_q[map_waddr] <= map_wdata;
  end

  logic [9:0]  px_col;
  logic [8:0]  px_row;
  logic [10:0] pix_idx;

  assign px_col  = ADDRH >> TILE_SHIFT;
  assign px_row  = ADDRV >> TILE_SHIFT;
  assign pix_idx = 11'(px_row) * 11'(GRID_W) + 11'(px_col);

  always_comb begin
    COLOUR_IN = COL_EMPTY;
    if (!CLEAR_BUSY && (32'(px_col) < GRID_W) && (32'(px_row) < GRID_H)) begin
      case (map_q[pix_idx])
        2'd1:    COLOUR_IN = COL_BODY;
        2'd2:    COLOUR_IN = COL_HEAD;
        2'd3:    COLOUR_IN = COL_FOOD;
        default: COLOUR_IN = COL_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Bench for snake_tile_renderer: directed scenarios plus randomized write batches, checked against
// a 2-D tile-map model that applies pending writes in order whenever a vsync window is opened.
module tb_snake_tile_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic        VS;
  logic [11:0] COLOUR_IN;
  logic        WR_VALID;
  logic        WR_READY;
  logic [5:0]  WR_COL;
  logic [4:0]  WR_ROW;
  logic [1:0]  WR_TILE;
  logic        CLEAR_REQ;
  logic        CLEAR_BUSY;

  always #5 clk = ~clk;

  snake_tile_renderer dut (
    .clk(clk), .RESET(rst), .ADDRH(ADDRH), .ADDRV(ADDRV), .VS(VS), .COLOUR_IN(COLOUR_IN),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_COL(WR_COL), .WR_ROW(WR_ROW),
    .WR_TILE(WR_TILE), .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY)
  );

  int tests = 0;
  int fails = 0;

  logic [1:0]  model_map [30][40];
  logic [12:0] pend [$];

  function automatic logic [11:0] pal(input logic [1:0] t);
    case (t)
      2'd1:    return 12'h0F0;
      2'd2:    return 12'hFF0;
      2'd3:    return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] exp_colour(input int x, input int y);
    if (x / 16 >= 40 || y / 16 >= 30) return 12'h000;
    return pal(model_map[y / 16][x / 16]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) model_map[r][c] = 2'd0;
    pend.delete();
  endtask

  task automatic model_apply();
    foreach (pend[i]) begin
      int c, r;
      c = int'(pend[i][12:7]);
      r = int'(pend[i][6:2]);
      if (c < 40 && r < 30) model_map[r][c] = pend[i][1:0];
    end
    pend.delete();
  endtask

  task automatic push(input int c, input int r, input int t);
    int n;
    n = 0;
    WR_VALID = 1'b1;
    WR_COL   = 6'(c);
    WR_ROW   = 5'(r);
    WR_TILE  = 2'(t);
    while (!WR_READY && n < 50) begin
      tick();
      n++;
    end
    check("push_ready_timeout", 32'(n < 50), 32'd1);
    tick();
    WR_VALID = 1'b0;
    pend.push_back({6'(c), 5'(r), 2'(t)});
  endtask

  task automatic drain();
    VS = 1'b0;
    repeat (8) tick();
    VS = 1'b1;
    model_apply();
  endtask

  task automatic check_pixel(input string tag, input int x, input int y);
    ADDRH = 10'(x);
    ADDRV = 9'(y);
    #1;
    check(tag, 32'(COLOUR_IN), 32'(exp_colour(x, y)));
  endtask

  task automatic check_tile(input string tag, input int c, input int r, input logic [11:0] exp);
    ADDRH = 10'(c * 16 + 7);
    ADDRV = 9'(r * 16 + 7);
    #1;
    check(tag, 32'(COLOUR_IN), 32'(exp));
  endtask

  task automatic sweep(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) begin
        ADDRH = 10'(c * 16 + (r % 16));
        ADDRV = 9'(r * 16 + (c % 16));
        #1;
        if (COLOUR_IN !== exp_colour(c * 16 + (r % 16), r * 16 + (c % 16))) bad++;
      end
    check(tag, 32'(bad), 32'd0);
    tick();
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (CLEAR_BUSY && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'd1200);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; VS = 1'b1; WR_VALID = 1'b0; WR_COL = '0; WR_ROW = '0; WR_TILE = '0;
    CLEAR_REQ = 1'b0; ADDRH = 10'd100; ADDRV = 9'd100;

    // Scenario 1: reset values, wipe length, idle map.
    #12;
    check("rst_wr_ready", 32'(WR_READY), 32'd0);
    check("rst_clear_busy", 32'(CLEAR_BUSY), 32'd1);
    check("rst_colour", 32'(COLOUR_IN), 32'h000);
    tick(); tick();
    rst = 1'b0;
    model_clear();
    wait_clear("s1_clear_cycles");
    check("s1_wr_ready", 32'(WR_READY), 32'd1);
    sweep("s1_all_empty");

    // Scenario 2: write held while VS high, committed in the vsync window.
    push(5, 3, 2);
    repeat (3) tick();
    check_tile("s2_not_committed", 5, 3, 12'h000);
    drain();
    ADDRH = 10'd80; ADDRV = 9'd48; #1;
    check("s2_head_tl", 32'(COLOUR_IN), 32'hFF0);
    ADDRH = 10'd95; ADDRV = 9'd63; #1;
    check("s2_head_br", 32'(COLOUR_IN), 32'hFF0);
    ADDRH = 10'd96; ADDRV = 9'd48; #1;
    check("s2_right_neighbour", 32'(COLOUR_IN), 32'h000);

    // Scenario 3: full FIFO back-pressure, in-order commits on consecutive cycles.
    for (int i = 0; i < 4; i++) push(i, 0, (i % 3) + 1);
    check("s3_full_ready", 32'(WR_READY), 32'd0);
    WR_VALID = 1'b1; WR_COL = 6'd4; WR_ROW = 5'd0; WR_TILE = 2'd2;
    repeat (2) tick();
    check("s3_held_ready", 32'(WR_READY), 32'd0);
    VS = 1'b0;
    tick();
    check_tile("s3_e0_pre", 0, 0, 12'h000);
    tick();
    check_tile("s3_e0", 0, 0, 12'h0F0);
    check_tile("s3_e1_pre", 1, 0, 12'h000);
    check("s3_ready_after_pop", 32'(WR_READY), 32'd1);
    tick();
    WR_VALID = 1'b0;
    check_tile("s3_e1", 1, 0, 12'hFF0);
    check_tile("s3_e2_pre", 2, 0, 12'h000);
    tick();
    check_tile("s3_e2", 2, 0, 12'hF00);
    check_tile("s3_e3_pre", 3, 0, 12'h000);
    tick();
    check_tile("s3_e3", 3, 0, 12'h0F0);
    check_tile("s3_e4_pre", 4, 0, 12'h000);
    tick();
    check_tile("s3_e4", 4, 0, 12'hFF0);
    VS = 1'b1;
    pend.push_back({6'd4, 5'd0, 2'd2});
    model_apply();
    sweep("s3_sweep");

    // Scenario 4: out-of-grid entry dropped, bottom-right corner tile, out-of-grid pixels.
    push(45, 3, 3);
    push(39, 29, 1);
    drain();
    ADDRH = 10'd639; ADDRV = 9'd479; #1;
    check("s4_corner", 32'(COLOUR_IN), 32'h0F0);
    check_pixel("s4_alias_cell", 5 * 16 + 2, 4 * 16 + 2);
    check_pixel("s4_row3_right", 639, 48);
    check_pixel("s4_x_out", 1000, 100);
    check_pixel("s4_y_out", 100, 500);

    // Randomized batches near the grid edge so cells collide and some entries fall outside.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++)
        push(int'($urandom_range(34, 47)), int'($urandom_range(25, 31)), int'($urandom_range(0, 3)));
      drain();
      sweep("rnd_sweep");
      check_pixel("rnd_pixel", int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    end

    // Scenario 5: CLEAR_REQ with pending entries in a vsync window; same-cycle write discarded.
    push(10, 10, 3);
    push(11, 10, 3);
    CLEAR_REQ = 1'b1; VS = 1'b0;
    WR_VALID = 1'b1; WR_COL = 6'd12; WR_ROW = 5'd10; WR_TILE = 2'd1;
    check("s5_ready_at_req", 32'(WR_READY), 32'd1);
    tick();
    CLEAR_REQ = 1'b0; WR_VALID = 1'b0;
    check("s5_busy", 32'(CLEAR_BUSY), 32'd1);
    check("s5_ready_low", 32'(WR_READY), 32'd0);
    check_tile("s5_blank_during_clear", 5, 3, 12'h000);
    model_clear();
    wait_clear("s5_clear_cycles");
    repeat (4) tick();
    VS = 1'b1;
    sweep("s5_all_empty");

    // Scenario 6: reset asserted mid-DRAIN.
    push(20, 5, 1);
    push(21, 5, 2);
    push(22, 5, 3);
    VS = 1'b0;
    tick(); tick();
    check_tile("s6_first_commit", 20, 5, 12'h0F0);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_ready", 32'(WR_READY), 32'd0);
    check("s6_rst_busy", 32'(CLEAR_BUSY), 32'd1);
    check("s6_rst_colour", 32'(COLOUR_IN), 32'h000);
    tick(); tick();
    rst = 1'b0;
    model_clear();
    wait_clear("s6_clear_cycles");
    repeat (4) tick();
    VS = 1'b1;
    check("s6_wr_ready", 32'(WR_READY), 32'd1);
    sweep("s6_all_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
